// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch stage with a DEPTH-entry output queue.
//   Owns the PC and issues in-order requests to instruction memory (req_*).
//   Responses (rsp_*) arrive in order with no backpressure. Each response is
//   paired with the PC it was issued for and queued for decode (out_*).
//   A redirect (redir_*) retargets the PC, clears the queue and marks every
//   response still in flight as stale, so those responses are dropped.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready/req_addr      fetch request to instruction memory
//   rsp_valid/rsp_data                in-order instruction response
//   out_valid/out_ready/out_pc/out_inst   queue head to decode
//   redir_valid/src/base/imm/jaddr/reg    redirect from downstream

// One queue slot. Kept as its own module so the storage is a flat array of
// identical instances.
module fetch_queue_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module fetch_queue_unit #(
  parameter int          W_ADDR   = 32,
  parameter int          W_INST   = 32,
  parameter int          W_IMM    = 16,
  parameter int          W_JADDR  = 26,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [W_ADDR-1:0]  req_addr,
  input  logic               rsp_valid,
  input  logic [W_INST-1:0]  rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_ADDR-1:0]  out_pc,
  output logic [W_INST-1:0]  out_inst,
  input  logic               redir_valid,
  input  logic [1:0]         redir_src,
  input  logic [W_ADDR-1:0]  redir_base,
  input  logic [W_IMM-1:0]   redir_imm,
  input  logic [W_JADDR-1:0] redir_jaddr,
  input  logic [W_ADDR-1:0]  redir_reg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);
  // Low PC bits replaced by a jump: jaddr field plus the 2 word-offset bits.
  localparam logic [W_ADDR-1:0] JLO_MASK =
    {{(W_ADDR-W_JADDR-2){1'b0}}, {(W_JADDR+2){1'b1}}};

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BRCH = 2'd1;
  localparam logic [1:0] SRC_JUMP = 2'd2;
  localparam logic [1:0] SRC_REGF = 2'd3;

  typedef struct packed {
    logic [W_ADDR-1:0] pc;
    logic [W_INST-1:0] inst;
  } fq_ent_t;
  localparam int W_ENT = $bits(fq_ent_t);

  logic [W_ADDR-1:0]              pc;
  logic [CW-1:0]                  count, outstanding, drop;
  logic [AW-1:0]                  q_hd, q_tl;
  // Addresses of requests in flight, oldest at pf_hd; popped per response.
  logic [DEPTH-1:0][W_ADDR-1:0]   pf_mem;
  logic [AW-1:0]                  pf_hd, pf_tl;
  logic [DEPTH-1:0][W_ENT-1:0]    ent_q;
  logic [DEPTH-1:0]               ent_we;
  fq_ent_t                        wr_ent, head_ent;

  logic                           redir_act, issue, pop, push, q_nonempty;
  logic [W_ADDR-1:0]              base_inc, imm_sext, br_off, tgt;

  // ---------------- handshakes ----------------
  assign redir_act  = redir_valid & (redir_src != SRC_NONE);
  assign q_nonempty = (count != '0);

  // Credit rule: queued + in-flight never exceeds DEPTH, so every response
  // is guaranteed a free slot.
  assign req_valid = ~rst & ~redir_valid &
                     (({1'b0, count} + {1'b0, outstanding}) < DEPTH_S);
  assign req_addr  = pc;
  assign issue     = req_valid & req_ready;

  assign out_valid = ~rst & ~redir_valid & q_nonempty;
  assign pop       = out_valid & out_ready;

  // A response is kept only when no stale responses remain ahead of it and
  // no redirect is flushing this cycle.
  assign push      = rsp_valid & ~redir_act & (drop == '0);

  // ---------------- queue storage ----------------
  always_comb begin
    wr_ent      = '0;
    wr_ent.pc   = pf_mem[pf_hd];
    wr_ent.inst = rsp_data;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign ent_we[gi] = push & (q_tl == AW'(gi));
    fetch_queue_entry #(.W(W_ENT)) u_ent (
      .clk (clk),
      .rst (rst),
      .we  (ent_we[gi]),
      .d   (wr_ent),
      .q   (ent_q[gi])
    );
  end

  assign head_ent = fq_ent_t'(ent_q[q_hd]);
  // Outputs read zero whenever nothing is queued (and throughout reset).
  assign out_pc   = (~rst & q_nonempty) ? head_ent.pc   : '0;
  assign out_inst = (~rst & q_nonempty) ? head_ent.inst : '0;

  // ---------------- redirect target ----------------
  always_comb begin
    base_inc = redir_base + W_ADDR'(4);
    imm_sext = {{(W_ADDR-W_IMM){redir_imm[W_IMM-1]}}, redir_imm};
    br_off   = imm_sext << 2;
    tgt      = pc;
    case (redir_src)
      SRC_BRCH: tgt = base_inc + br_off;
      SRC_JUMP: tgt = (base_inc & ~JLO_MASK) | W_ADDR'({redir_jaddr, 2'b00});
      SRC_REGF: tgt = redir_reg;
      default:  tgt = pc;
    endcase
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= W_ADDR'(RESET_PC);
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      q_hd        <= '0;
      q_tl        <= '0;
      pf_hd       <= '0;
      pf_tl       <= '0;
    end else begin
      // In-flight tracking runs regardless of redirects: stale responses
      // still retire their request and their PC FIFO slot.
      outstanding <= outstanding + CW'(issue) - CW'(rsp_valid);
      if (issue) begin
        pf_mem[pf_tl] <= pc;
        pf_tl         <= pf_tl + 1'b1;
      end
      if (rsp_valid) pf_hd <= pf_hd + 1'b1;

      if (redir_act) begin
        pc    <= tgt;
        count <= '0;
        q_hd  <= '0;
        q_tl  <= '0;
        // Every response still owed to an older request is now stale. No
        // issue can happen this cycle, so outstanding holds only old ones;
        // a response arriving now is itself discarded.
        drop  <= outstanding - CW'(rsp_valid);
      end else begin
        if (issue) pc <= pc + W_ADDR'(4);
        if (push)  q_tl <= q_tl + 1'b1;
        if (pop)   q_hd <= q_hd + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (rsp_valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        redir_valid;
  logic [1:0]  redir_src;
  logic [31:0] redir_base;
  logic [15:0] redir_imm;
  logic [25:0] redir_jaddr;
  logic [31:0] redir_reg;

  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .redir_valid(redir_valid), .redir_src(redir_src),
    .redir_base(redir_base), .redir_imm(redir_imm),
    .redir_jaddr(redir_jaddr), .redir_reg(redir_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: each accepted request carries the redirect epoch it was
  // issued in; the reference queue only takes responses of the live epoch.
  typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } eent_t;
  mreq_t mq[$];
  eent_t eq[$];
  logic [31:0] mpc;
  int epoch, cyc, n_acc;
  int npass, nchk;

  // Stimulus knobs, consumed by step().
  int rdy_pct, ordy_pct, lat_lo, lat_hi;
  bit d_rst, d_rv;
  logic [1:0]  d_src;
  logic [31:0] d_base, d_reg;
  logic [15:0] d_imm;
  logic [25:0] d_jaddr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0001;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [1:0] s, input logic [31:0] b,
                                         input logic [15:0] im, input logic [25:0] j,
                                         input logic [31:0] r, input logic [31:0] cur);
    int off;
    off = int'($signed(im)) * 4;
    case (s)
      2'd1:    return b + 32'd4 + 32'(off);
      2'd2:    return ((b + 32'd4) & 32'hF000_0000) | (32'(j) << 2);
      2'd3:    return r;
      default: return cur;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model,
  // then let the posedge happen.
  task automatic step();
    bit exp_rv, exp_ov, rd, acc, pp;
    mreq_t m;
    eent_t e;
    int due;
    @(negedge clk);
    rst         = d_rst;
    req_ready   = ($urandom_range(99) < rdy_pct);
    out_ready   = ($urandom_range(99) < ordy_pct);
    redir_valid = d_rv;
    redir_src   = d_src;
    redir_base  = d_base;
    redir_imm   = d_imm;
    redir_jaddr = d_jaddr;
    redir_reg   = d_reg;
    rsp_valid   = 1'b0;
    rsp_data    = 32'h0;
    if (!d_rst && mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = inst_of(mq[0].addr);
    end
    #1;
    if (d_rst) begin
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      mq.delete();
      eq.delete();
      mpc = 32'd0;
      epoch++;
    end else begin
      rd     = d_rv && (d_src != 2'd0);
      exp_rv = !d_rv && (eq.size() + mq.size() < DEPTH);
      exp_ov = !d_rv && (eq.size() > 0);
      chk("req_valid", 32'(req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", req_addr, mpc);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (eq.size() > 0) begin
        chk("out_pc", out_pc, eq[0].pc);
        chk("out_inst", out_inst, eq[0].inst);
      end
      if (req_valid && req_ready) n_acc++;
      acc = exp_rv && req_ready;
      pp  = exp_ov && out_ready;
      if (pp) void'(eq.pop_front());
      if (rsp_valid) begin
        m = mq.pop_front();
        if (!rd && m.ep == epoch) begin
          e.pc = m.addr; e.inst = inst_of(m.addr);
          eq.push_back(e);
        end
      end
      if (acc) begin
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (mq.size() > 0 && due < mq[$].due) due = mq[$].due;
        m.addr = mpc; m.ep = epoch; m.due = due;
        mq.push_back(m);
        mpc = mpc + 32'd4;
      end
      if (rd) begin
        eq.delete();
        epoch++;
        mpc = tgt_of(d_src, d_base, d_imm, d_jaddr, d_reg, mpc);
      end
    end
    @(posedge clk);
    cyc++;
    d_rv = 1'b0;
    d_src = 2'd0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redir(input logic [1:0] s, input logic [31:0] b, input logic [15:0] im,
                       input logic [25:0] j, input logic [31:0] r);
    d_rv = 1'b1; d_src = s; d_base = b; d_imm = im; d_jaddr = j; d_reg = r;
    step();
  endtask

  initial begin
    npass = 0; nchk = 0; cyc = 0; epoch = 0; n_acc = 0; mpc = 32'd0;
    rst = 1'b1; req_ready = 1'b0; out_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    redir_valid = 1'b0; redir_src = '0; redir_base = '0; redir_imm = '0;
    redir_jaddr = '0; redir_reg = '0;
    d_rv = 1'b0; d_src = '0; d_base = '0; d_imm = '0; d_jaddr = '0; d_reg = '0;
    rdy_pct = 100; ordy_pct = 100; lat_lo = 1; lat_hi = 1;

    // Reset
    d_rst = 1'b1; steps(3);
    d_rst = 1'b0;

    // Streaming, latency 1, always ready
    steps(12);

    // Decode stalled: only DEPTH requests accepted after a flush
    ordy_pct = 0;
    redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h0000_2000);
    n_acc = 0;
    steps(12);
    chk("stall_accepts", 32'(n_acc), 32'(DEPTH));
    ordy_pct = 100;
    steps(10);

    // Branch backwards with requests in flight
    lat_lo = 2; lat_hi = 2;
    steps(4);
    redir(2'd1, 32'h0000_0100, 16'hFFFE, 26'h0, 32'h0);
    chk("brch_pc", mpc, 32'h0000_00FC);
    steps(8);

    // Jump and register redirects
    redir(2'd2, 32'hF000_0010, 16'h0, 26'h000_0040, 32'h0);
    chk("jump_pc", mpc, 32'hF000_0100);
    steps(6);
    redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h1234_5678);
    steps(6);

    // Response and pop coinciding with a redirect, then back-to-back
    lat_lo = 1; lat_hi = 1;
    steps(4);
    redir(2'd1, 32'h0000_0400, 16'h0010, 26'h0, 32'h0);
    redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h0000_8000);
    steps(6);

    // redir_src=0 only masks the handshakes
    redir(2'd0, 32'hDEAD_0000, 16'h1, 26'h1, 32'hDEAD_BEEF);
    steps(6);

    // PC wrap at the top of the address space
    redir(2'd3, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFF8);
    steps(8);

    // Mid-stream reset with entries queued and requests in flight
    ordy_pct = 0; lat_lo = 3; lat_hi = 3;
    steps(4);
    d_rst = 1'b1; steps(2);
    d_rst = 1'b0;
    ordy_pct = 100; lat_lo = 1; lat_hi = 1;
    steps(6);

    // Randomised traffic with occasional redirects
    rdy_pct = 70; ordy_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 6)
        redir(2'($urandom_range(3)), $urandom, 16'($urandom), 26'($urandom), $urandom);
      else
        step();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
